// File: rtl/bp_io_dev_scheduler.sv
// Round-robin scheduler for the shared uncached device port: one transaction in flight,
// with address decode, a response timeout and error completion so that no requester can hang.
module bp_io_dev_scheduler #(
    parameter int num_req_p     = 2,
    parameter int num_dev_p     = 5,
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 64,
    parameter int timeout_p     = 255
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p*paddr_width_p-1:0]   req_addr_i,
    input  logic [num_req_p-1:0]                 req_w_i,
    input  logic [num_req_p*data_width_p-1:0]    req_data_i,
    output logic [num_req_p-1:0]                 req_ready_o,
    output logic                                 dev_v_o,
    output logic [num_dev_p-1:0]                 dev_sel_o,
    output logic [19:0]                          dev_addr_o,
    output logic                                 dev_w_o,
    output logic [data_width_p-1:0]              dev_data_o,
    input  logic                                 dev_ready_i,
    input  logic                                 dev_resp_v_i,
    input  logic [data_width_p-1:0]              dev_resp_data_i,
    output logic [num_req_p-1:0]                 resp_v_o,
    output logic [data_width_p-1:0]              resp_data_o,
    output logic                                 resp_err_o,
    input  logic [num_req_p-1:0]                 resp_ready_i
);

    localparam int GW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int CW = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

    state_e                   state_q, state_d;
    logic [GW-1:0]            gnt_q, gnt_d, last_q, last_d;
    logic [num_dev_p-1:0]     sel_q, sel_d;
    logic [19:0]              offs_q, offs_d;
    logic                     w_q, w_d;
    logic [data_width_p-1:0]  wdata_q, wdata_d;
    logic [data_width_p-1:0]  rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic [num_req_p-1:0][paddr_width_p-1:0] req_addr_a;
    logic [num_req_p-1:0][data_width_p-1:0]  req_data_a;
    logic [paddr_width_p-1:0] win_addr;
    logic [GW-1:0]            rr_idx;
    logic                     rr_found;
    logic                     legal;
    logic                     tmo;

    assign req_addr_a = req_addr_i;
    assign req_data_a = req_data_i;

    // Search starts just past the last granted requester and wraps around.
    always_comb begin
        logic [GW-1:0] idx;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = GW'((int'(last_q) + i) % num_req_p);
            if (!rr_found && req_v_i[idx]) begin
                rr_found = 1'b1;
                rr_idx   = idx;
            end
        end
    end

    assign win_addr = req_addr_a[rr_idx];
    assign legal    = (win_addr[paddr_width_p-1:24] == '0) && (int'(win_addr[23:20]) < num_dev_p);
    assign tmo      = (cnt_q == CW'(timeout_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(num_req_p - 1);
            sel_q   <= '0;
            offs_q  <= '0;
            w_q     <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            offs_q  <= offs_d;
            w_q     <= w_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        offs_d  = offs_q;
        w_d     = w_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    gnt_d   = rr_idx;
                    sel_d   = num_dev_p'(1) << win_addr[23:20];
                    offs_d  = win_addr[19:0];
                    w_d     = req_w_i[rr_idx];
                    wdata_d = req_data_a[rr_idx];
                    rdata_d = '0;
                    err_d   = !legal;
                    cnt_d   = '0;
                    state_d = legal ? SEND : RESP;
                end
            end
            SEND: begin
                cnt_d = cnt_q + CW'(1);
                if (dev_ready_i) state_d = WAIT;
                if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A response landing on the timeout cycle still completes cleanly.
                if (dev_resp_v_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = w_q ? '0 : dev_resp_data_i;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: begin
                if (resp_ready_i[gnt_q]) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        resp_v_o    = '0;
        dev_v_o     = (state_q == SEND);
        dev_sel_o   = dev_v_o ? sel_q : '0;
        dev_addr_o  = dev_v_o ? offs_q : '0;
        dev_w_o     = dev_v_o & w_q;
        dev_data_o  = dev_v_o ? wdata_q : '0;
        resp_data_o = rdata_q;
        resp_err_o  = err_q;
        if (state_q == IDLE && rr_found) req_ready_o = num_req_p'(1) << rr_idx;
        if (state_q == RESP)             resp_v_o    = num_req_p'(1) << gnt_q;
    end

endmodule

// File: tb/tb_bp_io_dev_scheduler.sv
// Bench for bp_io_dev_scheduler: table of single transactions plus hand-built sequences for
// arbitration, command stall, timeout, timeout/response tie and reset in flight.
module tb_bp_io_dev_scheduler;
  localparam int NR = 2, ND = 5, PW = 40, DW = 64, TMO = 255;

  logic                    clk_i = 1'b0;
  logic                    reset_n_i;
  logic [NR-1:0]           req_v_i;
  logic [NR-1:0][PW-1:0]   req_addr_i;
  logic [NR-1:0]           req_w_i;
  logic [NR-1:0][DW-1:0]   req_data_i;
  logic [NR-1:0]           req_ready_o;
  logic                    dev_v_o;
  logic [ND-1:0]           dev_sel_o;
  logic [19:0]             dev_addr_o;
  logic                    dev_w_o;
  logic [DW-1:0]           dev_data_o;
  logic                    dev_ready_i;
  logic                    dev_resp_v_i;
  logic [DW-1:0]           dev_resp_data_i;
  logic [NR-1:0]           resp_v_o;
  logic [DW-1:0]           resp_data_o;
  logic                    resp_err_o;
  logic [NR-1:0]           resp_ready_i;

  bp_io_dev_scheduler dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_addr_i(req_addr_i), .req_w_i(req_w_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .dev_v_o(dev_v_o), .dev_sel_o(dev_sel_o), .dev_addr_o(dev_addr_o), .dev_w_o(dev_w_o),
    .dev_data_o(dev_data_o), .dev_ready_i(dev_ready_i), .dev_resp_v_i(dev_resp_v_i),
    .dev_resp_data_i(dev_resp_data_i),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_ready_i(resp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          r;
    logic [PW-1:0] addr;
    logic          w;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [ND-1:0] sel;
    logic [19:0]   daddr;
    logic          err;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic          r;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  int   checks = 0, failures = 0;
  exp_t sb[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s actual=response required=empty_scoreboard", nm);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_resp_v"}, 64'(resp_v_o), 64'(NR'(1) << e.r));
    chk({nm, "_resp_data"}, resp_data_o, e.data);
    chk({nm, "_resp_err"}, 64'(resp_err_o), 64'(e.err));
  endtask

  task automatic wait_resp(input string nm, input int lim);
    int n = 0;
    while (resp_v_o == '0 && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    if (resp_v_o == '0) begin
      checks++; failures++;
      $display("FAIL %s_resp_timeout actual=none required=response_within_%0d", nm, lim);
      if (sb.size() != 0) void'(sb.pop_front());
    end else pop_check(nm);
  endtask

  task automatic drive_req(input logic r, input logic [PW-1:0] a, input logic w, input logic [DW-1:0] d);
    req_v_i[r]    = 1'b1;
    req_addr_i[r] = a;
    req_w_i[r]    = w;
    req_data_i[r] = d;
  endtask

  task automatic handshake(input logic r);
    resp_ready_i = NR'(1) << r;
    @(negedge clk_i);
    resp_ready_i = '0;
  endtask

  task automatic do_txn(input vec_t v, input string nm);
    sb.push_back('{v.r, v.err, v.exp_data});
    @(negedge clk_i);
    drive_req(v.r, v.addr, v.w, v.wdata);
    #1 chk({nm, "_ready"}, 64'(req_ready_o), 64'(NR'(1) << v.r));
    @(negedge clk_i);
    req_v_i = '0;
    if (v.sel != '0) begin
      chk({nm, "_dev_v"}, 64'(dev_v_o), 64'd1);
      chk({nm, "_dev_sel"}, 64'(dev_sel_o), 64'(v.sel));
      chk({nm, "_dev_addr"}, 64'(dev_addr_o), 64'(v.daddr));
      chk({nm, "_dev_w"}, 64'(dev_w_o), 64'(v.w));
      chk({nm, "_dev_data"}, dev_data_o, v.wdata);
      dev_ready_i = 1'b1;
      @(negedge clk_i);
      dev_ready_i     = 1'b0;
      dev_resp_data_i = v.rdata;
      dev_resp_v_i    = 1'b1;
      @(negedge clk_i);
      dev_resp_v_i = 1'b0;
    end else begin
      chk({nm, "_no_dev_v"}, 64'(dev_v_o), 64'd0);
    end
    wait_resp(nm, 5);
    handshake(v.r);
    chk({nm, "_resp_clear"}, 64'(resp_v_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_m;
    logic early;

    tbl[0] = '{1'b0, 40'h00_0030_bff8, 1'b0, 64'h0, 64'h1234, 5'b01000, 20'hbff8, 1'b0, 64'h1234};
    tbl[1] = '{1'b1, 40'h00_0050_0000, 1'b0, 64'h0, 64'h0, 5'b00000, 20'h0, 1'b1, 64'h0};
    tbl[2] = '{1'b1, 40'h01_0000_0000, 1'b0, 64'h0, 64'h0, 5'b00000, 20'h0, 1'b1, 64'h0};
    tbl[3] = '{1'b1, 40'h00_004a_bcde, 1'b1, 64'hdead_beef, 64'hffff, 5'b10000, 20'habcde, 1'b0, 64'h0};
    tbl[4] = '{1'b0, 40'h00_0000_0010, 1'b0, 64'h0, 64'hcafe_f00d_1234_5678, 5'b00001, 20'h00010, 1'b0, 64'hcafe_f00d_1234_5678};
    tbl[5] = '{1'b1, 40'h00_002f_ffff, 1'b0, 64'h0, 64'h0bad_0000_0000_0001, 5'b00100, 20'hfffff, 1'b0, 64'h0bad_0000_0000_0001};
    tbl[6] = '{1'b0, 40'h00_00f0_0000, 1'b1, 64'h77, 64'h0, 5'b00000, 20'h0, 1'b1, 64'h0};
    tbl[7] = '{1'b1, 40'h00_0010_0004, 1'b1, 64'h5a5a_a5a5, 64'h1111, 5'b00010, 20'h00004, 1'b0, 64'h0};

    reset_n_i = 1'b0;
    req_v_i = '0; req_addr_i = '0; req_w_i = '0; req_data_i = '0;
    dev_ready_i = 1'b0; dev_resp_v_i = 1'b0; dev_resp_data_i = '0; resp_ready_i = '0;
    #1;
    chk("rst_dev_v", 64'(dev_v_o), 64'd0);
    chk("rst_resp_v", 64'(resp_v_o), 64'd0);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", 64'(req_ready_o), 64'd0);
    chk("idle_resp_err", 64'(resp_err_o), 64'd0);

    for (int i = 0; i < 8; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Both requesters hold requests; previous winner was requester 1.
    @(negedge clk_i);
    drive_req(1'b0, 40'h00_0020_0000, 1'b0, 64'h0);
    drive_req(1'b1, 40'h00_0010_0000, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = 1'(i % 2);
      sb.push_back('{g, 1'b0, 64'h100 + 64'(i)});
      #1 chk($sformatf("rr%0d_ready", i), 64'(req_ready_o), 64'(NR'(1) << g));
      @(negedge clk_i);
      chk($sformatf("rr%0d_busy_ready", i), 64'(req_ready_o), 64'd0);
      chk($sformatf("rr%0d_sel", i), 64'(dev_sel_o), g ? 64'h02 : 64'h04);
      dev_ready_i = 1'b1;
      @(negedge clk_i);
      dev_ready_i = 1'b0; dev_resp_v_i = 1'b1; dev_resp_data_i = 64'h100 + 64'(i);
      @(negedge clk_i);
      dev_resp_v_i = 1'b0;
      wait_resp($sformatf("rr%0d", i), 3);
      resp_ready_i = 2'b11;
      @(negedge clk_i);
      resp_ready_i = '0;
    end
    req_v_i = '0;

    // Command stalled for 10 cycles, accepted on the 11th.
    sb.push_back('{1'b0, 1'b0, 64'h0});
    @(negedge clk_i);
    drive_req(1'b0, 40'h00_0030_4000, 1'b1, 64'h0123_4567_89ab_cdef);
    @(negedge clk_i);
    req_v_i = '0;
    for (int m = 0; m < 10; m++) begin
      chk($sformatf("stall%0d_dev_v", m), 64'(dev_v_o), 64'd1);
      chk($sformatf("stall%0d_fields", m), 64'({dev_sel_o, dev_addr_o, dev_w_o}), 64'({5'b01000, 20'h04000, 1'b1}));
      chk($sformatf("stall%0d_data", m), dev_data_o, 64'h0123_4567_89ab_cdef);
      @(negedge clk_i);
    end
    chk("stall_still_v", 64'(dev_v_o), 64'd1);
    dev_ready_i = 1'b1;
    @(negedge clk_i);
    dev_ready_i = 1'b0;
    chk("stall_accepted", 64'(dev_v_o), 64'd0);
    dev_resp_v_i = 1'b1; dev_resp_data_i = 64'hffff;
    @(negedge clk_i);
    dev_resp_v_i = 1'b0;
    wait_resp("stall", 3);
    handshake(1'b0);

    // Device accepts but never answers: error exactly TMO cycles after entering SEND.
    sb.push_back('{1'b1, 1'b1, 64'h0});
    @(negedge clk_i);
    drive_req(1'b1, 40'h00_0030_0000, 1'b0, 64'h0);
    @(negedge clk_i);
    req_v_i = '0;
    chk("tmo_dev_v", 64'(dev_v_o), 64'd1);
    dev_ready_i = 1'b1;
    first_m = -1;
    for (int m = 1; m <= TMO + 5 && first_m < 0; m++) begin
      @(negedge clk_i);
      dev_ready_i = 1'b0;
      if (resp_v_o != '0) first_m = m;
    end
    chk("tmo_cycles", 64'(first_m), 64'(TMO));
    pop_check("tmo");
    dev_resp_v_i = 1'b1; dev_resp_data_i = 64'h5555;
    resp_ready_i = 2'b01;
    @(negedge clk_i);
    dev_resp_v_i = 1'b0; resp_ready_i = '0;
    chk("tmo_late_v", 64'(resp_v_o), 64'h2);
    chk("tmo_late_data", resp_data_o, 64'h0);
    chk("tmo_late_err", 64'(resp_err_o), 64'd1);
    handshake(1'b1);
    dev_resp_v_i = 1'b1;
    @(negedge clk_i);
    dev_resp_v_i = 1'b0;
    chk("idle_resp_ignored", 64'(resp_v_o), 64'd0);

    // Response lands on the timeout cycle: completes without error.
    sb.push_back('{1'b0, 1'b0, 64'habcd});
    drive_req(1'b0, 40'h00_0040_0008, 1'b0, 64'h0);
    @(negedge clk_i);
    req_v_i = '0;
    dev_ready_i = 1'b1;
    early = 1'b0;
    for (int m = 1; m < TMO; m++) begin
      @(negedge clk_i);
      dev_ready_i = 1'b0;
      if (resp_v_o != '0) early = 1'b1;
    end
    chk("tie_quiet", 64'(early), 64'd0);
    dev_resp_v_i = 1'b1; dev_resp_data_i = 64'habcd;
    @(negedge clk_i);
    dev_resp_v_i = 1'b0;
    pop_check("tie");
    handshake(1'b0);

    // Reset while WAITing on requester 1; requester 0 must win afterwards.
    @(negedge clk_i);
    drive_req(1'b1, 40'h00_0010_0100, 1'b1, 64'h9999);
    @(negedge clk_i);
    req_v_i = '0;
    dev_ready_i = 1'b1;
    @(negedge clk_i);
    dev_ready_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("wrst_dev_v", 64'(dev_v_o), 64'd0);
    chk("wrst_dev_fields", 64'({dev_sel_o, dev_addr_o, dev_w_o}), 64'd0);
    chk("wrst_dev_data", dev_data_o, 64'h0);
    chk("wrst_resp_v", 64'(resp_v_o), 64'd0);
    chk("wrst_resp_data", resp_data_o, 64'h0);
    chk("wrst_resp_err", 64'(resp_err_o), 64'd0);
    chk("wrst_ready", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    dev_resp_v_i = 1'b1;
    @(negedge clk_i);
    dev_resp_v_i = 1'b0;
    chk("wrst_no_resp", 64'(resp_v_o), 64'd0);
    sb.push_back('{1'b0, 1'b1, 64'h0});
    drive_req(1'b0, 40'h00_0060_0000, 1'b0, 64'h0);
    drive_req(1'b1, 40'h00_0010_0000, 1'b0, 64'h0);
    #1 chk("wrst_first_grant", 64'(req_ready_o), 64'h1);
    @(negedge clk_i);
    req_v_i = '0;
    wait_resp("wrst_txn", 3);
    handshake(1'b0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
